// File: rtl/bt_cmd_scheduler.sv
// Bluetooth command scheduler: decodes UART command bytes into a small FIFO
// and dispatches at most one direction per player (plus ghost requests) per game tick.
module bt_cmd_scheduler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    input  logic                     tick,
    input  logic                     play,
    output logic [3:0]               p1_btn_n,
    output logic [3:0]               p2_btn_n,
    output logic [1:0]               ghost_req,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Direction codes double as bit positions in the {left,right,up,down} bus,
    // so opposite directions differ only in bit 0.
    localparam logic [1:0] D_DOWN  = 2'd0;
    localparam logic [1:0] D_UP    = 2'd1;
    localparam logic [1:0] D_RIGHT = 2'd2;
    localparam logic [1:0] D_LEFT  = 2'd3;

    typedef struct packed {
        logic       player;
        logic       ghost;
        logic [1:0] dir;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DISPATCH, COMMIT} state_t;

    cmd_t               mem_q [DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      count_q, count_d, exam_q, exam_d;
    logic               rx_valid_q;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [1:0]         served_q, served_d, ghost_q, ghost_d;
    logic [1:0][1:0]    staged_q, staged_d, last_dir_q, last_dir_d;
    logic [1:0]         last_vld_q, last_vld_d;
    logic [3:0]         p1_q, p1_d, p2_q, p2_d;
    logic [1:0]         ghost_req_q, ghost_req_d;

    cmd_t               dec, head;
    logic               dec_ok, accept, push, pop, full, empty;
    logic [1:0]         drop_inc;
    logic [CNT_W:0]     drop_sum;

    assign accept = rx_valid & ~rx_valid_q;
    assign head   = mem_q[rd_q];
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);

    always_comb begin
        dec_ok = 1'b1;
        dec    = '0;
        case (rx_byte)
            8'h01:   dec = {1'b0, 1'b0, D_DOWN};
            8'h02:   dec = {1'b0, 1'b0, D_RIGHT};
            8'h03:   dec = {1'b0, 1'b0, D_LEFT};
            8'h04:   dec = {1'b0, 1'b0, D_UP};
            8'h05:   dec = {1'b1, 1'b0, D_UP};
            8'h06:   dec = {1'b1, 1'b0, D_LEFT};
            8'h07:   dec = {1'b1, 1'b0, D_RIGHT};
            8'h08:   dec = {1'b1, 1'b0, D_DOWN};
            8'h09:   dec = {1'b0, 1'b1, 2'd0};
            8'h00:   dec = {1'b1, 1'b1, 2'd0};
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        served_d    = served_q;
        staged_d    = staged_q;
        ghost_d     = ghost_q;
        exam_d      = exam_q;
        last_vld_d  = last_vld_q;
        last_dir_d  = last_dir_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        ghost_req_d = '0;
        overflow_d  = overflow_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        count_d     = count_q;
        pop         = 1'b0;
        push        = 1'b0;
        drop_inc    = '0;

        if (!play) begin
            state_d    = IDLE;
            pend_d     = 1'b0;
            last_vld_d = '0;
            p1_d       = 4'hF;
            p2_d       = 4'hF;
            rd_d       = '0;
            wr_d       = '0;
            count_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick || pend_q) begin
                        state_d  = DISPATCH;
                        pend_d   = 1'b0;
                        served_d = '0;
                        ghost_d  = '0;
                        exam_d   = '0;
                    end
                end
                DISPATCH: begin
                    if (tick) pend_d = 1'b1;
                    // A second direction for a served player blocks the head until next tick.
                    if (empty || exam_q == DEPTH_C || (!head.ghost && served_q[head.player])) begin
                        state_d = COMMIT;
                    end else begin
                        pop    = 1'b1;
                        exam_d = exam_q + 1'b1;
                        if (head.ghost) begin
                            ghost_d[head.player] = 1'b1;
                        end else if (last_vld_q[head.player] &&
                                     head.dir == (last_dir_q[head.player] ^ 2'b01)) begin
                            drop_inc = 2'd1;
                        end else begin
                            served_d[head.player] = 1'b1;
                            staged_d[head.player] = head.dir;
                        end
                    end
                end
                COMMIT: begin
                    if (tick) pend_d = 1'b1;
                    state_d     = IDLE;
                    ghost_req_d = ghost_q;
                    p1_d = served_q[0] ? ~(4'b0001 << staged_q[0]) : 4'hF;
                    p2_d = served_q[1] ? ~(4'b0001 << staged_q[1]) : 4'hF;
                    if (served_q[0]) begin
                        last_vld_d[0] = 1'b1;
                        last_dir_d[0] = staged_q[0];
                    end
                    if (served_q[1]) begin
                        last_vld_d[1] = 1'b1;
                        last_dir_d[1] = staged_q[1];
                    end
                end
                default: state_d = IDLE;
            endcase

            if (accept) begin
                if (!dec_ok) begin
                    drop_inc = drop_inc + 2'd1;
                end else if (full && !pop) begin
                    overflow_d = 1'b1;
                    drop_inc   = drop_inc + 2'd1;
                end else begin
                    push = 1'b1;
                end
            end

            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end

        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= dec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid_q  <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            exam_q      <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            served_q    <= '0;
            staged_q    <= '0;
            ghost_q     <= '0;
            last_vld_q  <= '0;
            last_dir_q  <= '0;
            p1_q        <= 4'hF;
            p2_q        <= 4'hF;
            ghost_req_q <= '0;
        end else begin
            rx_valid_q  <= rx_valid;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            exam_q      <= exam_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
            served_q    <= served_d;
            staged_q    <= staged_d;
            ghost_q     <= ghost_d;
            last_vld_q  <= last_vld_d;
            last_dir_q  <= last_dir_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            ghost_req_q <= ghost_req_d;
        end
    end

    assign p1_btn_n   = p1_q;
    assign p2_btn_n   = p2_q;
    assign ghost_req  = ghost_req_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_bt_cmd_scheduler.sv
// Bench for bt_cmd_scheduler: directed and random byte/tick sequences checked
// against a queue-based model of the command rules.
module tb_bt_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int MAXD  = (1 << CNT_W) - 1;

    localparam logic [3:0] UP    = 4'b1101;
    localparam logic [3:0] DOWN  = 4'b1110;
    localparam logic [3:0] RIGHT = 4'b1011;
    localparam logic [3:0] LEFT  = 4'b0111;
    localparam logic [3:0] NONE  = 4'hF;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [7:0]             rx_byte;
    logic                   rx_valid;
    logic                   tick;
    logic                   play;
    logic [3:0]             p1_btn_n, p2_btn_n;
    logic [1:0]             ghost_req;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_cnt;

    bt_cmd_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tick(tick), .play(play), .p1_btn_n(p1_btn_n), .p2_btn_n(p2_btn_n),
        .ghost_req(ghost_req), .fifo_count(fifo_count), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pl;
        bit         gh;
        logic [3:0] pat;
    } mcmd_t;

    mcmd_t      q[$];
    int         m_drop;
    bit         m_ovf;
    logic [3:0] e_p[2];
    logic [3:0] last[2];
    logic [1:0] e_g;
    int         n_pass, n_fail, n_total;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] opp(input logic [3:0] d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            default: return NONE;
        endcase
    endfunction

    function automatic bit tb_decode(input logic [7:0] b, output mcmd_t c);
        c = '{pl: 0, gh: 1'b0, pat: NONE};
        case (b)
            8'h01: c = '{pl: 0, gh: 1'b0, pat: DOWN};
            8'h02: c = '{pl: 0, gh: 1'b0, pat: RIGHT};
            8'h03: c = '{pl: 0, gh: 1'b0, pat: LEFT};
            8'h04: c = '{pl: 0, gh: 1'b0, pat: UP};
            8'h05: c = '{pl: 1, gh: 1'b0, pat: UP};
            8'h06: c = '{pl: 1, gh: 1'b0, pat: LEFT};
            8'h07: c = '{pl: 1, gh: 1'b0, pat: RIGHT};
            8'h08: c = '{pl: 1, gh: 1'b0, pat: DOWN};
            8'h09: c = '{pl: 0, gh: 1'b1, pat: NONE};
            8'h00: c = '{pl: 1, gh: 1'b1, pat: NONE};
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic sat_inc();
        if (m_drop < MAXD) m_drop++;
    endtask

    task automatic model_reset();
        q.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
        e_p[0] = NONE; e_p[1] = NONE;
        last[0] = NONE; last[1] = NONE;
        e_g = 2'b00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        mcmd_t c;
        if (!tb_decode(b, c)) sat_inc();
        else if (q.size() == DEPTH) begin
            m_ovf = 1'b1;
            sat_inc();
        end else q.push_back(c);
    endtask

    // One tick: walk the queue head applying the per-player rules, then commit.
    task automatic model_tick(output int k);
        bit         served[2];
        bit         gl[2];
        logic [3:0] stg[2];
        mcmd_t      h;
        served[0] = 0; served[1] = 0; gl[0] = 0; gl[1] = 0;
        stg[0] = NONE; stg[1] = NONE;
        k = 0;
        while (k < DEPTH && q.size() > 0) begin
            h = q[0];
            if (h.gh) gl[h.pl] = 1'b1;
            else if (served[h.pl]) break;
            else if (last[h.pl] != NONE && h.pat == opp(last[h.pl])) sat_inc();
            else begin
                served[h.pl] = 1'b1;
                stg[h.pl] = h.pat;
            end
            void'(q.pop_front());
            k++;
        end
        for (int p = 0; p < 2; p++) begin
            e_p[p] = served[p] ? stg[p] : NONE;
            if (served[p]) last[p] = stg[p];
        end
        e_g = {gl[1], gl[0]};
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        step();
        model_byte(b);
        chk("send_count", fifo_count, q.size());
        chk("send_drop", drop_cnt, m_drop);
        chk("send_ovf", overflow, m_ovf);
    endtask

    task automatic do_tick();
        logic [3:0] o1, o2;
        int k;
        o1 = e_p[0]; o2 = e_p[1];
        model_tick(k);
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 1; i <= k + 1; i++) begin
            step();
            chk("hold_p1", p1_btn_n, o1);
            chk("hold_p2", p2_btn_n, o2);
            chk("hold_ghost", ghost_req, 2'b00);
        end
        step();
        chk("commit_p1", p1_btn_n, e_p[0]);
        chk("commit_p2", p2_btn_n, e_p[1]);
        chk("commit_ghost", ghost_req, e_g);
        chk("commit_count", fifo_count, q.size());
        chk("commit_drop", drop_cnt, m_drop);
        step();
        chk("ghost_pulse_end", ghost_req, 2'b00);
    endtask

    // Second tick lands during the first dispatch and must be replayed right after.
    task automatic do_tick2();
        logic [3:0] a1, a2, b1, b2;
        logic [1:0] ga, gb;
        int k1, k2;
        model_tick(k1);
        a1 = e_p[0]; a2 = e_p[1]; ga = e_g;
        model_tick(k2);
        b1 = e_p[0]; b2 = e_p[1]; gb = e_g;
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        for (int i = 2; i <= k1 + k2 + 5; i++) begin
            step();
            if (i == k1 + 2) begin
                chk("pend_first_p1", p1_btn_n, a1);
                chk("pend_first_p2", p2_btn_n, a2);
                chk("pend_first_ghost", ghost_req, ga);
            end
            if (i == k1 + k2 + 4) chk("pend_not_yet_p1", p1_btn_n, a1);
            if (i == k1 + k2 + 5) begin
                chk("pend_second_p1", p1_btn_n, b1);
                chk("pend_second_p2", p2_btn_n, b2);
                chk("pend_second_ghost", ghost_req, gb);
                chk("pend_second_drop", drop_cnt, m_drop);
            end
        end
        step();
    endtask

    task automatic drain();
        for (int n = 0; n < 8 && q.size() > 0; n++) do_tick();
    endtask

    initial begin
        int nb, r;
        logic [7:0] b;
        n_pass = 0; n_fail = 0; n_total = 0;
        reset = 1'b0; play = 1'b1; tick = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        model_reset();
        step(); step();
        chk("rst_p1", p1_btn_n, 4'hF);
        chk("rst_p2", p2_btn_n, 4'hF);
        chk("rst_ghost", ghost_req, 2'b00);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b1;
        step();

        // Single up for p1, latency t+3.
        send(8'h04);
        do_tick();
        // Both players served; p1's second direction waits, then is rejected as a reversal.
        send(8'h04); send(8'h06); send(8'h01);
        do_tick();
        do_tick();
        // Duplicate ghosts collapse into one pulse.
        send(8'h09); send(8'h09); send(8'h00);
        do_tick();
        // Overflow and invalid code.
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h06);
        send(8'h55);
        drain();

        // rx_valid held high accepts a single byte.
        rx_byte = 8'h02; rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rx_valid = 1'b0;
        step();
        model_byte(8'h02);
        chk("hold_valid_count", fifo_count, q.size());
        send(8'h07); send(8'h03);
        do_tick2();
        drain();

        // Dropping play mid-dispatch.
        send(last[1] == DOWN ? 8'h08 : 8'h05);
        do_tick();
        send(8'h07); send(8'h06);
        tick = 1'b1;
        step();
        tick = 1'b0; play = 1'b0;
        step();
        q.delete();
        last[0] = NONE; last[1] = NONE; e_p[0] = NONE; e_p[1] = NONE;
        chk("noplay_p1", p1_btn_n, 4'hF);
        chk("noplay_p2", p2_btn_n, 4'hF);
        chk("noplay_ghost", ghost_req, 2'b00);
        chk("noplay_count", fifo_count, 0);
        rx_byte = 8'h55; rx_valid = 1'b1; step(); rx_valid = 1'b0; step();
        rx_byte = 8'h01; rx_valid = 1'b1; step(); rx_valid = 1'b0; step();
        chk("noplay_drop", drop_cnt, m_drop);
        chk("noplay_count2", fifo_count, 0);
        play = 1'b1;
        step();
        send(8'h04);
        do_tick();

        // Random traffic against the model.
        for (int it = 0; it < 25; it++) begin
            nb = $urandom_range(0, 5);
            for (int j = 0; j < nb; j++) begin
                r = $urandom_range(0, 11);
                if (r <= 9) b = 8'(r);
                else if (r == 10) b = 8'h55;
                else b = 8'($urandom_range(10, 255));
                send(b);
            end
            do_tick();
        end
        drain();

        // Async reset in the middle of a dispatch.
        send(last[0] == DOWN ? 8'h01 : 8'h04);
        do_tick();
        send(8'h06); send(8'h07);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        reset = 1'b0;
        #2;
        model_reset();
        chk("midrst_p1", p1_btn_n, 4'hF);
        chk("midrst_p2", p2_btn_n, 4'hF);
        chk("midrst_ghost", ghost_req, 2'b00);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_drop", drop_cnt, 0);
        chk("midrst_ovf", overflow, 1'b0);
        reset = 1'b1;
        step();

        // drop_cnt saturation.
        for (int i = 0; i < MAXD + 5; i++) send(8'hAA);
        chk("drop_sat", drop_cnt, MAXD);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
